// File: rtl/ep_sched.sv
// ep_sched: weighted round-robin scheduler that hands a shared PCIe endpoint
// turn to one of four requesters, supervises the hold and times it out.

// Per-requester credit counter: reload to max(wgt,1), or count down by one.
module ep_credit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] wgt,
  input  logic       reload,
  input  logic       dec,
  output logic [3:0] credit
);
  // Reset credit is 1, so the first reload happens on first use or skip
  // and picks up whatever weight is live at that moment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         credit <= 4'd1;
    else if (reload) credit <= (wgt == 4'd0) ? 4'd1 : wgt;
    else if (dec)    credit <= credit - 4'd1;
  end
endmodule

module ep_sched #(
  parameter int TMO   = 1023,
  parameter int TMO_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chn_trn,
  output logic        chn_drvn,
  output logic        chn_reqep,
  input  logic [3:0]  req,
  input  logic [3:0]  drvn,
  input  logic [15:0] wgt,
  output logic [3:0]  trn,
  output logic [1:0]  gnt_id,
  output logic        tmo
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, HOLD} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      ptr;
  logic [TMO_W-1:0]                hold_cnt;
  logic [NUM_LANES-1:0][3:0]       wgt_l;
  logic [NUM_LANES-1:0][3:0]       credit;
  logic [NUM_LANES-1:0]            skip, reload, dec;
  logic [1:0]                      sel, idx;
  logic                            found, exhaust;
  logic                            do_grant, do_exit, do_tmo;

  assign wgt_l = wgt;

  // Round-robin search from ptr; requesters passed over on the way are
  // flagged so their credit gets refreshed.
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    skip  = '0;
    idx   = 2'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + 2'(k);
      if (!found) begin
        if (req[idx]) begin
          found = 1'b1;
          sel   = idx;
        end else begin
          skip[idx] = 1'b1;
        end
      end
    end
  end

  assign exhaust = (credit[sel] == 4'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and the grant/exit/timeout strobes.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_exit  = 1'b0;
    do_tmo   = 1'b0;
    case (state_q)
      IDLE:   state_d = WAIT;
      WAIT: begin
        if (chn_trn && found) begin
          do_grant = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: state_d = HOLD;
      HOLD: begin
        // Only drvn or the timeout ends the hold; req is not looked at.
        if (drvn == 4'd0) begin
          do_exit = 1'b1;
          state_d = WAIT;
        end else if (hold_cnt == TMO_W'(TMO - 1)) begin
          do_tmo  = 1'b1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane credit control: skipped or exhausted lanes reload, the granted
  // lane otherwise counts down; a timeout forces the holder to reload.
  always_comb begin
    reload = '0;
    dec    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      reload[i] = (do_grant && (skip[i] || (sel == 2'(i) && exhaust))) ||
                  (do_tmo && gnt_id == 2'(i));
      dec[i]    = do_grant && sel == 2'(i) && !exhaust;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ep_credit u_cred (
      .clk    (clk),
      .rst    (rst),
      .wgt    (wgt_l[i]),
      .reload (reload[i]),
      .dec    (dec[i]),
      .credit (credit[i])
    );
  end

  // Grant outputs, endpoint drive flag, timeout pulse and pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trn      <= '0;
      gnt_id   <= '0;
      chn_drvn <= 1'b0;
      tmo      <= 1'b0;
      ptr      <= '0;
    end else begin
      trn <= '0;
      tmo <= 1'b0;
      if (do_grant) begin
        trn      <= 4'b0001 << sel;
        gnt_id   <= sel;
        chn_drvn <= 1'b1;
        ptr      <= exhaust ? sel + 2'd1 : sel;
      end
      if (do_exit || do_tmo) chn_drvn <= 1'b0;
      if (do_tmo) begin
        tmo <= 1'b1;
        ptr <= gnt_id + 2'd1;
      end
    end
  end

  // Hold counter: cleared in SETTLE, counts HOLD cycles with drvn active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 hold_cnt <= '0;
    else if (state_q == SETTLE)              hold_cnt <= '0;
    else if (state_q == HOLD && drvn != '0)  hold_cnt <= hold_cnt + 1'b1;
  end

  // Request summary to upstream, independent of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chn_reqep <= 1'b0;
    else     chn_reqep <= |req;
  end
endmodule
